// File: rtl/mdu_pkg.sv
// Shared opcodes, default latencies and helpers for the multiply/divide unit.
package mdu_pkg;

    localparam int unsigned OP_W = 3;
    localparam int unsigned XLEN = 32;

    localparam logic [OP_W-1:0] MD_NONE  = 3'd0;
    localparam logic [OP_W-1:0] MD_MULT  = 3'd1;
    localparam logic [OP_W-1:0] MD_MULTU = 3'd2;
    localparam logic [OP_W-1:0] MD_DIV   = 3'd3;
    localparam logic [OP_W-1:0] MD_DIVU  = 3'd4;
    localparam logic [OP_W-1:0] MD_MTHI  = 3'd5;
    localparam logic [OP_W-1:0] MD_MTLO  = 3'd6;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    function automatic logic is_mul_op(input logic [OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the HI/LO pair for one op.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] res_hi,
    output logic [XLEN-1:0] res_lo,
    output logic            div_by_zero
);

    logic signed [2*XLEN-1:0] sa_ext;
    logic signed [2*XLEN-1:0] sb_ext;
    logic signed [2*XLEN-1:0] prod_s;
    logic        [2*XLEN-1:0] prod_u;
    logic        [XLEN-1:0]   divisor;
    logic signed [XLEN-1:0]   sdividend;
    logic signed [XLEN-1:0]   sdivisor;
    logic signed [XLEN-1:0]   squot;
    logic signed [XLEN-1:0]   srem;
    logic        [XLEN-1:0]   uquot;
    logic        [XLEN-1:0]   urem;

    // A zero divisor is replaced by one so the dividers never see X; the result is discarded anyway.
    always_comb begin
        sa_ext    = {{XLEN{a[XLEN-1]}}, a};
        sb_ext    = {{XLEN{b[XLEN-1]}}, b};
        prod_s    = sa_ext * sb_ext;
        prod_u    = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        divisor   = (b == '0) ? XLEN'(1) : b;
        sdividend = a;
        sdivisor  = divisor;
        squot     = sdividend / sdivisor;
        srem      = sdividend % sdivisor;
        uquot     = a / divisor;
        urem      = a % divisor;
    end

    always_comb begin
        res_hi      = '0;
        res_lo      = '0;
        div_by_zero = 1'b0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                res_hi      = srem;
                res_lo      = squot;
                div_by_zero = (b == '0);
            end
            MD_DIVU: begin
                res_hi      = urem;
                res_lo      = uquot;
                div_by_zero = (b == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: fixed-latency busy counter, HI/LO ownership and D-stage stall request.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    input  logic            md_use,
    output logic            busy,
    output logic            stall,
    output logic [31:0]     hi,
    output logic [31:0]     lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  shadow_hi;
    logic [XLEN-1:0]  shadow_lo;
    logic             shadow_dz;
    logic [XLEN-1:0]  res_hi;
    logic [XLEN-1:0]  res_lo;
    logic             div_by_zero;

    mdu_arith u_arith (
        .op          (op),
        .a           (a),
        .b           (b),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (div_by_zero)
    );

    // Result is captured at issue; HI/LO only change when the counter expires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            busy      <= 1'b0;
            shadow_hi <= '0;
            shadow_lo <= '0;
            shadow_dz <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
                if (!shadow_dz) begin
                    hi <= shadow_hi;
                    lo <= shadow_lo;
                end
            end
        end else if (start) begin
            if (is_mul_op(op) || is_div_op(op)) begin
                shadow_hi <= res_hi;
                shadow_lo <= res_lo;
                shadow_dz <= div_by_zero;
                busy      <= 1'b1;
                cnt       <= is_mul_op(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end else if (op == MD_MTHI) begin
                hi <= a;
            end else if (op == MD_MTLO) begin
                lo <= a;
            end
        end
    end

    // Combinational so the dependent instruction stalls in the same cycle its producer is in E.
    assign stall = md_use & (start | busy);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with hand-computed HI/LO results.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_err;

    mdu_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .md_use (md_use),
        .busy   (busy),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after the issuing edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = MD_NONE;
        a     = '0;
        b     = '0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(o, x, y);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(busy), 32'd0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b0;
        start  = 1'b0;
        op     = MD_NONE;
        a      = '0;
        b      = '0;
        md_use = 1'b0;

        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(MD_MTHI, 32'h1234, 32'h0);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_busy", 32'(busy), 32'd0);
        issue(MD_MTLO, 32'h5678, 32'h0);
        check("mtlo_lo", lo, 32'h5678);
        check("mtlo_hi", hi, 32'h1234);

        run_op("divu0", MD_DIVU, 32'd7, 32'd0, 10, 32'h1234, 32'h5678);

        // Undefined opcode must leave everything untouched.
        issue(3'd7, 32'hAAAA_AAAA, 32'h5555_5555);
        check("undef_busy", 32'(busy), 32'd0);
        check("undef_hi", hi, 32'h1234);
        check("undef_lo", lo, 32'h5678);

        md_use = 1'b1;
        check("idle_stall", 32'(stall), 32'd0);
        start = 1'b1;
        op    = MD_MULT;
        a     = 32'd6;
        b     = 32'd7;
        #1;
        check("start_stall", 32'(stall), 32'd1);
        @(negedge clk);
        start = 1'b0;
        op    = MD_NONE;
        for (int i = 0; i < 5; i++) begin
            check("busy_stall", 32'(stall), 32'd1);
            @(negedge clk);
        end
        check("post_stall", 32'(stall), 32'd0);
        check("stall_hi", hi, 32'h0);
        check("stall_lo", lo, 32'd42);
        md_use = 1'b0;

        // MTHI while busy must be dropped.
        issue(MD_MULT, 32'hFFFF_FFFF, 32'd4);
        @(negedge clk);
        issue(MD_MTHI, 32'hDEAD, 32'h0);
        check("mid_mthi_hi", hi, 32'h0);
        check("mid_mthi_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        check("mid_done_busy", 32'(busy), 32'd0);
        check("mid_done_hi", hi, 32'hFFFF_FFFF);
        check("mid_done_lo", lo, 32'hFFFF_FFFC);

        // Reset in the middle of a divide loses the operation.
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_hi", hi, 32'h0);
        check("mid_rst_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("lost_busy", 32'(busy), 32'd0);
        check("lost_hi", hi, 32'h0);
        check("lost_lo", lo, 32'h0);

        run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
